// File: rtl/bridge_frame_decoder_if.sv
// ---------------------------------------------------------------------------
// bridge_frame_decoder_if
// Device-side request/response bus between the frame decoder and the bridge
// master port.
//   daddr  : transaction address            (decoder -> port)
//   dwdata : write data                     (decoder -> port)
//   dmode  : 0 = read, 1 = write            (decoder -> port)
//   dvalid : transaction request            (decoder -> port)
//   dready : master port idle / ready       (port -> decoder)
//   drdata : read data                      (port -> decoder)
// Modports: master = frame decoder side, slave = master-port side.
// ---------------------------------------------------------------------------
interface bridge_frame_decoder_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] daddr;
   logic [DATA_WIDTH-1:0] dwdata;
   logic                  dmode;
   logic                  dvalid;
   logic                  dready;
   logic [DATA_WIDTH-1:0] drdata;

   modport master (
      output daddr, dwdata, dmode, dvalid,
      input  dready, drdata
   );

   modport slave (
      input  daddr, dwdata, dmode, dvalid,
      output dready, drdata
   );
endinterface

// File: rtl/bridge_frame_decoder.sv
// ---------------------------------------------------------------------------
// bridge_frame_decoder
// Assembles byte-serial command frames from the UART receiver into single
// bus transactions and returns a one-byte response to the UART transmitter.
// Frame: command (00 = read, 01 = write), ADDR_BYTES address bytes MSB first,
// then one data byte for writes. Exactly one transaction is outstanding.
//
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   rx_data, rx_valid  : received byte and its one-cycle strobe
//   tx_data, tx_valid  : response byte, held until tx_ready
//   tx_ready           : transmitter accepts the byte
//   dbus (master)      : device-side bus towards the master port
//   frame_err          : one-cycle pulse on bad command byte or timeout
//   rx_drop            : one-cycle pulse when a byte arrives outside parsing
// ---------------------------------------------------------------------------
module bridge_frame_decoder #(
   parameter int         ADDR_WIDTH     = 16,    // multiple of 8, 8..32
   parameter int         DATA_WIDTH     = 8,     // only 8 supported
   parameter int         TIMEOUT_CYCLES = 1000,  // minimum 2
   parameter logic [7:0] ACK_BYTE       = 8'hAA
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   bridge_frame_decoder_if.master dbus,
   output logic                   frame_err,
   output logic                   rx_drop
);

   localparam int               ADDR_BYTES     = ADDR_WIDTH / 8;
   localparam int               TMO_W          = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST       = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]       LAST_ADDR_BYTE = 3'(ADDR_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                state;
   logic [2:0]            byte_cnt;
   logic [TMO_W-1:0]      tmo_cnt;
   logic                  seen_busy;
   logic [ADDR_WIDTH-1:0] daddr_q;
   logic [DATA_WIDTH-1:0] dwdata_q;
   logic                  dmode_q;
   logic                  dvalid_q;

   logic [ADDR_WIDTH-1:0] addr_shift;
   logic                  tmo_fire;

   // Written as a shift-and-or so an 8-bit address (one byte) needs no
   // special-case slice.
   assign addr_shift = (daddr_q << 8) | ADDR_WIDTH'(rx_data);
   assign tmo_fire   = (tmo_cnt == TMO_LAST);

   assign dbus.daddr  = daddr_q;
   assign dbus.dwdata = dwdata_q;
   assign dbus.dmode  = dmode_q;
   assign dbus.dvalid = dvalid_q;

   // NOTE: every register here is updated with <= so all branches see the
   // values from before the edge; mixing in = would make the result depend
   // on statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         byte_cnt  <= '0;
         tmo_cnt   <= '0;
         seen_busy <= 1'b0;
         daddr_q   <= '0;
         dwdata_q  <= '0;
         dmode_q   <= 1'b0;
         dvalid_q  <= 1'b0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         frame_err <= 1'b0;
         rx_drop   <= 1'b0;
      end else begin
         // Pulse outputs default low; a branch below raises them for one cycle.
         frame_err <= 1'b0;
         rx_drop   <= 1'b0;

         unique case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  if (rx_data[7:1] == 7'd0) begin
                     dmode_q  <= rx_data[0];
                     byte_cnt <= '0;
                     tmo_cnt  <= '0;
                     state    <= S_ADDR;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end

            S_ADDR: begin
               // Timeout takes priority over a byte arriving the same cycle.
               if (tmo_fire) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
               end else if (rx_valid) begin
                  daddr_q  <= addr_shift;
                  tmo_cnt  <= '0;
                  byte_cnt <= byte_cnt + 3'd1;
                  if (byte_cnt == LAST_ADDR_BYTE) begin
                     if (dmode_q) begin
                        state <= S_DATA;
                     end else begin
                        dvalid_q <= 1'b1;
                        state    <= S_ISSUE;
                     end
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (tmo_fire) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
               end else if (rx_valid) begin
                  dwdata_q <= DATA_WIDTH'(rx_data);
                  dvalid_q <= 1'b1;
                  state    <= S_ISSUE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            S_ISSUE: begin
               rx_drop <= rx_valid;
               if (dvalid_q && dbus.dready) begin
                  dvalid_q  <= 1'b0;
                  seen_busy <= 1'b0;
                  state     <= S_WAIT;
               end
            end

            S_WAIT: begin
               // The port may still look ready right after acceptance; only a
               // ready seen after a busy phase marks completion.
               rx_drop <= rx_valid;
               if (!dbus.dready) begin
                  seen_busy <= 1'b1;
               end else if (seen_busy) begin
                  tx_data  <= dmode_q ? ACK_BYTE : 8'(dbus.drdata);
                  tx_valid <= 1'b1;
                  state    <= S_RESP;
               end
            end

            S_RESP: begin
               rx_drop <= rx_valid;
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  state    <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bridge_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_bridge_frame_decoder
// Directed bench for bridge_frame_decoder: write and read frames, response
// hold, bad command, inter-byte timeout, dropped bytes and mid-transaction
// reset. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_bridge_frame_decoder;

   localparam int         ADDR_WIDTH     = 16;
   localparam int         DATA_WIDTH     = 8;
   localparam int         TIMEOUT_CYCLES = 20;
   localparam logic [7:0] ACK_BYTE       = 8'hAA;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       frame_err;
   logic       rx_drop;

   int n_checks = 0;
   int n_pass   = 0;

   bridge_frame_decoder_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dbus ();

   bridge_frame_decoder #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .ACK_BYTE      (ACK_BYTE)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .dbus     (dbus),
      .frame_err(frame_err),
      .rx_drop  (rx_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Advance n rising edges; inputs/outputs are touched 1ns after the edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_daddr"},  32'(dbus.daddr),  32'h0);
      check({tag, "_dwdata"}, 32'(dbus.dwdata), 32'h0);
      check({tag, "_dmode"},  32'(dbus.dmode),  32'h0);
      check({tag, "_dvalid"}, 32'(dbus.dvalid), 32'h0);
      check({tag, "_txdata"}, 32'(tx_data),     32'h0);
      check({tag, "_txvalid"},32'(tx_valid),    32'h0);
      check({tag, "_ferr"},   32'(frame_err),   32'h0);
      check({tag, "_drop"},   32'(rx_drop),     32'h0);
   endtask

   // Full frame -> issue -> 5 busy cycles -> completion -> zero-wait response.
   task automatic run_txn(input string tag, input logic mode, input logic [15:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rdata);
      dbus.dready = 1'b0;
      tx_ready    = 1'b0;
      send_byte({7'd0, mode});
      send_byte(addr[15:8]);
      send_byte(addr[7:0]);
      if (mode) send_byte(wdata);
      check({tag, "_dvalid"}, 32'(dbus.dvalid), 32'h1);
      check({tag, "_daddr"},  32'(dbus.daddr),  32'(addr));
      check({tag, "_dmode"},  32'(dbus.dmode),  32'(mode));
      if (mode) check({tag, "_dwdata"}, 32'(dbus.dwdata), 32'(wdata));
      dbus.dready = 1'b1;
      tick(1);
      check({tag, "_accepted"}, 32'(dbus.dvalid), 32'h0);
      dbus.dready = 1'b0;
      tick(5);
      check({tag, "_busy_txv"}, 32'(tx_valid), 32'h0);
      dbus.drdata = rdata;
      dbus.dready = 1'b1;
      tick(1);
      check({tag, "_txvalid"}, 32'(tx_valid), 32'h1);
      check({tag, "_txdata"},  32'(tx_data),  mode ? 32'(ACK_BYTE) : 32'(rdata));
      tx_ready = 1'b1;
      tick(1);
      check({tag, "_txdone"}, 32'(tx_valid), 32'h0);
      tx_ready = 1'b0;
   endtask

   initial begin
      rstn        = 1'b0;
      rx_data     = 8'h00;
      rx_valid    = 1'b0;
      tx_ready    = 1'b0;
      dbus.dready = 1'b1;
      dbus.drdata = 8'h00;

      // Reset state
      #3;
      check_all_zero("reset");
      tick(2);
      rstn = 1'b1;
      tick(1);

      // Write frame 01,12,34,5A -> ACK
      run_txn("wr", 1'b1, 16'h1234, 8'h5A, 8'h00);

      // Read frame 00,0F,FE with held response and dropped bytes
      dbus.dready = 1'b0;
      send_byte(8'h00);
      send_byte(8'h0F);
      send_byte(8'hFE);
      check("rd_dvalid", 32'(dbus.dvalid), 32'h1);
      check("rd_daddr",  32'(dbus.daddr),  32'h0FFE);
      check("rd_dmode",  32'(dbus.dmode),  32'h0);
      send_byte(8'h77);                       // strobed during ISSUE (not accepted yet)
      check("rd_drop_issue", 32'(rx_drop), 32'h1);
      check("rd_still_issue", 32'(dbus.dvalid), 32'h1);
      dbus.dready = 1'b1;
      tick(1);
      check("rd_accepted", 32'(dbus.dvalid), 32'h0);
      dbus.dready = 1'b0;
      send_byte(8'h55);                       // strobed during WAIT
      check("rd_drop_wait", 32'(rx_drop), 32'h1);
      tick(1);
      check("rd_drop_clear", 32'(rx_drop), 32'h0);
      check("rd_wait_txv", 32'(tx_valid), 32'h0);
      dbus.drdata = 8'hC3;
      dbus.dready = 1'b1;
      tick(1);
      dbus.drdata = 8'h00;                    // must already be captured
      check("rd_txvalid", 32'(tx_valid), 32'h1);
      check("rd_txdata",  32'(tx_data),  32'hC3);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) send_byte(8'h66);        // strobed during RESP
         else tick(1);
         check($sformatf("rd_hold_v%0d", i), 32'(tx_valid), 32'h1);
         check($sformatf("rd_hold_d%0d", i), 32'(tx_data),  32'hC3);
         check($sformatf("rd_hold_drop%0d", i), 32'(rx_drop), (i == 1) ? 32'h1 : 32'h0);
      end
      tx_ready = 1'b1;
      tick(1);
      check("rd_txdone", 32'(tx_valid), 32'h0);
      tx_ready = 1'b0;

      // Bad command then a normal read
      send_byte(8'h7E);
      check("bad_ferr", 32'(frame_err), 32'h1);
      check("bad_no_dvalid", 32'(dbus.dvalid), 32'h0);
      tick(1);
      check("bad_ferr_pulse", 32'(frame_err), 32'h0);
      check("bad_idle_dvalid", 32'(dbus.dvalid), 32'h0);
      run_txn("after_bad", 1'b0, 16'h0010, 8'h00, 8'h5C);

      // Timeout after 01,12
      send_byte(8'h01);
      send_byte(8'h12);
      tick(TIMEOUT_CYCLES - 1);
      check("tmo_not_yet", 32'(frame_err), 32'h0);
      tick(1);
      check("tmo_ferr", 32'(frame_err), 32'h1);
      tick(1);
      check("tmo_ferr_pulse", 32'(frame_err), 32'h0);
      run_txn("after_tmo", 1'b0, 16'hABCD, 8'h00, 8'h3E);

      // Byte on the cycle the timeout fires: timeout wins, no rx_drop
      send_byte(8'h00);
      tick(TIMEOUT_CYCLES - 1);
      send_byte(8'h99);
      check("tmo_col_ferr", 32'(frame_err), 32'h1);
      check("tmo_col_drop", 32'(rx_drop),   32'h0);
      tick(1);

      // Asynchronous reset during WAIT
      dbus.dready = 1'b0;
      send_byte(8'h01);
      send_byte(8'hBE);
      send_byte(8'hEF);
      send_byte(8'h42);
      dbus.dready = 1'b1;
      tick(1);
      dbus.dready = 1'b0;
      tick(2);
      check("pre_rst_daddr", 32'(dbus.daddr), 32'hBEEF);
      rstn = 1'b0;
      #1;
      check_all_zero("async_rst");
      tick(1);
      rstn        = 1'b1;
      dbus.dready = 1'b1;
      tick(1);
      run_txn("after_rst", 1'b1, 16'h2468, 8'h9D, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
